// File: rtl/id_stage.sv
// id_stage
// RV32I decode stage feeding the integer ALU. Decodes OP and OP-IMM
// instructions, owns the 32x32 register file (x0 hard-wired to zero) and
// holds one decoded beat in a single output slot.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   fetch handshake, in_inst carries the instruction word
//   flush               drops the held beat and any same-cycle incoming beat
//   wb_en/wb_rd/wb_data register file write port
//   out_valid/out_ready execute handshake
//   out_op, out_op_imm, out_illegal  opcode class
//   out_funct3, out_funct7, out_rd   decoded fields
//   out_a, out_b        rs1 operand, rs2 operand or immediate
//
// Parameter
//   BYPASS  1: a same-cycle writeback to a source register is forwarded
//           into the captured operand; 0: register file value is used.
module id_stage #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_op,
    output logic        out_op_imm,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic        valid_q,   valid_d;
    logic        op_q,      op_d;
    logic        op_imm_q,  op_imm_d;
    logic        illegal_q, illegal_d;
    logic [2:0]  funct3_q,  funct3_d;
    logic [6:0]  funct7_q,  funct7_d;
    logic [31:0] a_q,       a_d;
    logic [31:0] b_q,       b_d;
    logic [4:0]  rd_q,      rd_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;

    logic [4:0]  rs1_idx, rs2_idx;
    logic [2:0]  dec_funct3;
    logic        is_op, is_op_imm, is_shift;
    logic [31:0] rs1_val, rs2_val;
    logic        capture, stall, wb_live;

    assign rs1_idx    = in_inst[19:15];
    assign rs2_idx    = in_inst[24:20];
    assign dec_funct3 = in_inst[14:12];
    assign is_op      = (in_inst[6:0] == OPC_OP);
    assign is_op_imm  = (in_inst[6:0] == OPC_OP_IMM);
    assign is_shift   = is_op_imm && (dec_funct3 == 3'b001 || dec_funct3 == 3'b101);

    assign in_ready = !rst && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready && !flush;
    assign stall    = valid_q && !out_ready;
    assign wb_live  = wb_en && (wb_rd != 5'd0);

    // Read ports; x0 check last so a (ignored) write to x0 can never leak in.
    always_comb begin
        rs1_val = rf_q[rs1_idx];
        rs2_val = rf_q[rs2_idx];
        if (BYPASS && wb_en && wb_rd == rs1_idx) rs1_val = wb_data;
        if (BYPASS && wb_en && wb_rd == rs2_idx) rs2_val = wb_data;
        if (rs1_idx == 5'd0) rs1_val = '0;
        if (rs2_idx == 5'd0) rs2_val = '0;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_live) rf_d[wb_rd] = wb_data;

        valid_d   = valid_q;
        op_d      = op_q;
        op_imm_d  = op_imm_q;
        illegal_d = illegal_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;

        // A stalled beat picks up writebacks to its sources so execute sees
        // the newest value; immediates (and illegal beats) are left alone.
        if (stall && wb_live) begin
            if ((op_q || op_imm_q) && wb_rd == rs1_q) a_d = wb_data;
            if (op_q && wb_rd == rs2_q)               b_d = wb_data;
        end

        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            op_d      = is_op;
            op_imm_d  = is_op_imm;
            illegal_d = !(is_op || is_op_imm);
            funct3_d  = dec_funct3;
            rd_d      = in_inst[11:7];
            rs1_d     = rs1_idx;
            rs2_d     = rs2_idx;
            a_d       = (is_op || is_op_imm) ? rs1_val : 32'd0;
            funct7_d  = (is_op || is_shift) ? in_inst[31:25] : 7'd0;
            if (is_op)
                b_d = rs2_val;
            else if (is_shift)
                b_d = {27'd0, in_inst[24:20]};
            else if (is_op_imm)
                b_d = {{20{in_inst[31]}}, in_inst[31:20]};
            else
                b_d = 32'd0;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q      <= '{default: '0};
            valid_q   <= 1'b0;
            op_q      <= 1'b0;
            op_imm_q  <= 1'b0;
            illegal_q <= 1'b0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else begin
            rf_q      <= rf_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            op_imm_q  <= op_imm_d;
            illegal_q <= illegal_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_op      = op_q;
    assign out_op_imm  = op_imm_q;
    assign out_illegal = illegal_q;
    assign out_funct3  = funct3_q;
    assign out_funct7  = funct7_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_rd      = rd_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage
// Self-checking bench for id_stage: a decode vector table, hand-written
// stall/flush/reset sequences and randomized traffic compared against a
// behavioural model of the decode stage. A second instance with BYPASS=0
// is checked on the forwarding case.
module tb_id_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, wb_en, out_ready;
    logic [31:0] in_inst, wb_data;
    logic [4:0]  wb_rd;

    logic        in_ready, out_valid, out_op, out_op_imm, out_illegal;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;

    logic        z_in_ready, z_out_valid, z_out_op, z_out_op_imm, z_out_illegal;
    logic [2:0]  z_out_funct3;
    logic [6:0]  z_out_funct7;
    logic [31:0] z_out_a, z_out_b;
    logic [4:0]  z_out_rd;

    id_stage #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_op_imm(out_op_imm), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_illegal(out_illegal));

    id_stage #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_inst(in_inst), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(z_out_valid), .out_ready(out_ready),
        .out_op(z_out_op), .out_op_imm(z_out_op_imm), .out_funct3(z_out_funct3),
        .out_funct7(z_out_funct7), .out_a(z_out_a), .out_b(z_out_b),
        .out_rd(z_out_rd), .out_illegal(z_out_illegal));

    typedef struct packed {
        logic        valid, op, op_imm, ill;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b;
        logic [4:0]  rd, rs1, rs2;
    } slot_t;

    typedef struct {
        logic [31:0] inst;
        logic [81:0] exp;   // {op, op_imm, ill, f3, f7, a, b, rd}
    } vec_t;

    slot_t       cur;
    logic [31:0] rf_m [32];
    int          errs = 0;
    int          checks = 0;
    vec_t        vt [10];

    function automatic logic [81:0] pack(slot_t s);
        return {s.op, s.op_imm, s.ill, s.f3, s.f7, s.a, s.b, s.rd};
    endfunction

    function automatic logic [81:0] dut_fields();
        return {out_op, out_op_imm, out_illegal, out_funct3, out_funct7, out_a, out_b, out_rd};
    endfunction

    // Source operand as seen by a bypassing decode stage in this cycle.
    function automatic logic [31:0] src(logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return rf_m[r];
    endfunction

    function automatic slot_t decode(logic [31:0] inst);
        slot_t s = '0;
        logic [2:0] f3 = inst[14:12];
        s.valid = 1'b1;
        s.f3  = f3;
        s.rd  = inst[11:7];
        s.rs1 = inst[19:15];
        s.rs2 = inst[24:20];
        if (inst[6:0] == 7'h33) begin
            s.op = 1'b1;
            s.a  = src(s.rs1);
            s.b  = src(s.rs2);
            s.f7 = inst[31:25];
        end else if (inst[6:0] == 7'h13) begin
            s.op_imm = 1'b1;
            s.a = src(s.rs1);
            if (f3 == 3'd1 || f3 == 3'd5) begin
                s.b  = 32'(inst[24:20]);
                s.f7 = inst[31:25];
            end else begin
                s.b = 32'($signed(inst[31:20]));
            end
        end else begin
            s.ill = 1'b1;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock: check in_ready, advance the model, then compare the slot.
    task automatic tick();
        slot_t nxt;
        logic  exp_rdy;
        #1;
        exp_rdy = !rst && (!cur.valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        nxt = cur;
        if (cur.valid && !out_ready && wb_en && wb_rd != 5'd0) begin
            if ((cur.op || cur.op_imm) && wb_rd == cur.rs1) nxt.a = wb_data;
            if (cur.op && wb_rd == cur.rs2) nxt.b = wb_data;
        end
        if (rst) begin
            nxt = '0;
            for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        end else begin
            if (flush) nxt.valid = 1'b0;
            else if (in_valid && exp_rdy) nxt = decode(in_inst);
            else if (cur.valid && out_ready) nxt.valid = 1'b0;
            if (wb_en && wb_rd != 5'd0) rf_m[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
        cur = nxt;
        chk("out_valid", 32'(out_valid), 32'(cur.valid));
        if (cur.valid) begin
            checks++;
            if (dut_fields() !== pack(cur)) begin
                errs++;
                $display("FAIL slot actual=%h expected=%h", dut_fields(), pack(cur));
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        out_ready = 1'b1; wb_rd = 5'd0; wb_data = 32'd0; in_inst = 32'd0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        // rf: x1=12345678 x2=FFFF0000 x6=80000000 when the table runs
        vt[0] = '{32'h00500093, {3'b010, 3'd0, 7'h00, 32'h0,        32'h5,        5'd1}};
        vt[1] = '{32'h002081B3, {3'b100, 3'd0, 7'h00, 32'h12345678, 32'hFFFF0000, 5'd3}};
        vt[2] = '{32'h40335293, {3'b010, 3'd5, 7'h20, 32'h80000000, 32'h3,        5'd5}};
        vt[3] = '{32'h40208233, {3'b100, 3'd0, 7'h20, 32'h12345678, 32'hFFFF0000, 5'd4}};
        vt[4] = '{32'hFFF08393, {3'b010, 3'd0, 7'h00, 32'h12345678, 32'hFFFFFFFF, 5'd7}};
        vt[5] = '{32'h7F017413, {3'b010, 3'd7, 7'h00, 32'hFFFF0000, 32'h7F0,      5'd8}};
        vt[6] = '{32'h01F09493, {3'b010, 3'd1, 7'h00, 32'h12345678, 32'h1F,       5'd9}};
        vt[7] = '{32'h00000003, {3'b001, 3'd0, 7'h00, 32'h0,        32'h0,        5'd0}};
        vt[8] = '{32'h0040A183, {3'b001, 3'd2, 7'h00, 32'h0,        32'h0,        5'd3}};
        vt[9] = '{32'h00000533, {3'b100, 3'd0, 7'h00, 32'h0,        32'h0,        5'd10}};

        cur = '0;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        idle();

        // Reset, with a beat offered that must not be taken.
        rst = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);

        // ADDI x1,x0,5
        rst = 1'b0;
        tick();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_b", out_b, 32'd5);
        chk("addi_rd", 32'(out_rd), 32'd1);

        // Bypass: x2 written in the capture cycle of ADD x3,x1,x2.
        in_valid = 1'b0; wb(5'd1, 32'h12345678);
        tick();
        in_valid = 1'b1; in_inst = 32'h002081B3; wb(5'd2, 32'hFFFFFFFF);
        tick();
        chk("byp_a", out_a, 32'h12345678);
        chk("byp_b", out_b, 32'hFFFFFFFF);
        chk("byp_op", 32'(out_op), 32'd1);
        checks++;
        if ({z_in_ready, z_out_valid, z_out_op, z_out_op_imm, z_out_illegal, z_out_funct3,
             z_out_funct7, z_out_a, z_out_b, z_out_rd} !==
            {1'b1, 1'b1, 3'b100, 3'd0, 7'd0, 32'h12345678, 32'd0, 5'd3}) begin
            errs++;
            $display("FAIL nobyp_slot actual b=%h a=%h valid=%b expected b=0 a=12345678 valid=1",
                     z_out_b, z_out_a, z_out_valid);
        end

        // Register preload, then the decode table back to back.
        in_valid = 1'b0; wb(5'd2, 32'hFFFF0000); tick();
        wb(5'd6, 32'h80000000); tick();
        wb_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_inst = vt[i].inst;
            tick();
            checks++;
            if (dut_fields() !== vt[i].exp) begin
                errs++;
                $display("FAIL vec%0d actual=%h expected=%h", i, dut_fields(), vt[i].exp);
            end
        end
        in_valid = 1'b0; tick();

        // Stall with a refresh of rs1, then a single drain.
        in_valid = 1'b1; in_inst = 32'h002081B3; tick();
        out_ready = 1'b0; in_inst = 32'h00500093;
        tick();
        wb(5'd1, 32'hA5A5A5A5); tick();
        wb_en = 1'b0;
        chk("stall_ready", 32'(in_ready), 32'd0);
        chk("refresh_a", out_a, 32'hA5A5A5A5);
        chk("stall_b", out_b, 32'hFFFF0000);
        tick();
        chk("stall_rd", 32'(out_rd), 32'd3);
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        chk("drain_once", 32'(out_valid), 32'd0);
        tick();

        // Flush with a held beat and an incoming beat.
        in_valid = 1'b1; in_inst = 32'h002081B3; tick();
        in_inst = 32'h00100493; flush = 1'b1; tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0; tick(); tick();
        chk("flush_gone", 32'(out_valid), 32'd0);

        // Illegal opcode, x0 write ignored, x0 not bypassed.
        in_valid = 1'b1; in_inst = 32'h00000003; wb(5'd0, 32'hDEADBEEF); tick();
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_ops", 32'({out_op, out_op_imm}), 32'd0);
        in_inst = 32'h00000093; wb_en = 1'b0; tick();
        chk("x0_a", out_a, 32'd0);
        in_inst = 32'h00000533; wb(5'd0, 32'hDEADBEEF); tick();
        chk("x0_byp", out_a | out_b, 32'd0);
        wb_en = 1'b0;

        // Reset together with flush while a beat is held.
        in_inst = 32'h002081B3; out_ready = 1'b0; tick();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b0; tick();
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; tick();
        chk("rstmid_rf", out_a | out_b, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] inst;
            inst = $urandom;
            case ($urandom_range(0, 3))
                0, 1: inst[6:0] = 7'h33;
                2:    inst[6:0] = 7'h13;
                default: ;
            endcase
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
            in_inst   = inst;
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
